axil_slave_read_responder: RTL

- Local read target behind the AXI-Lite slave interface: consumes the captured read address and returns read data on the slave interface's module-side request/data pair.
- Holds a small register bank, writable from a local write port, and models fixed access latency with a down-counter.
- Replaces the bench-side counter-and-constant responder so that read paths can be checked end-to-end against real stored data.

---
 rtl/axil_slave_read_responder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axil_slave_read_responder.sv
// rtl/axil_slave_read_responder.sv - register-backed fixed-latency read responder behind the AXI-Lite slave
//
// Purpose:
//   Accepts one read strobe at a time from the slave interface, waits a fixed
//   LATENCY, then presents the addressed register on MOD_2_S_RDATA with
//   MOD_2_S_RRQST held until the read-data handshake. Strobes arriving while
//   busy are ignored and counted. A local write port loads the register bank.
//
// Ports:
//   ACLK           clock, rising edge
//   ARESET         synchronous active-high reset
//   S_2_MOD_RREQ   one-cycle read strobe, S_2_MOD_RADDR valid with it
//   S_2_MOD_RADDR  byte read address, word index taken from [IDX_BITS+1:2]
//   RREADY         read-data ready, beat accepted on MOD_2_S_RRQST && RREADY
//   MOD_2_S_RRQST  response valid
//   MOD_2_S_RDATA  response data, zero when no response is pending
//   WR_EN          local register write enable
//   WR_IDX         local write register index
//   WR_DATA        local write data
//   BUSY           a request is in progress (WAIT or RESP)
//   DROP_CNT       saturating count of ignored strobes
//   RD_ERR         response is an out-of-range error
//
// Build option:
//   AXIL_RESP_DECERR_EN  when defined, addresses >= 4*DEPTH return 32'hDEADBEEF
//                        with RD_ERR=1; otherwise they wrap into the bank and
//                        RD_ERR is held at 0.

module axil_slave_read_responder #(
   parameter int REG_WIDTH = 32,
   parameter int DEPTH     = 16,
   parameter int IDX_BITS  = 4,
   parameter int LATENCY   = 5
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic                 S_2_MOD_RREQ,
   input  logic [REG_WIDTH-1:0] S_2_MOD_RADDR,
   input  logic                 RREADY,
   output logic                 MOD_2_S_RRQST,
   output logic [REG_WIDTH-1:0] MOD_2_S_RDATA,
   input  logic                 WR_EN,
   input  logic [IDX_BITS-1:0]  WR_IDX,
   input  logic [REG_WIDTH-1:0] WR_DATA,
   output logic                 BUSY,
   output logic [7:0]           DROP_CNT,
   output logic                 RD_ERR
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [7:0]            cnt;
   logic [IDX_BITS-1:0]   idx_q;
   logic [REG_WIDTH-1:0]  reg_bank [DEPTH];
   logic                  rrqst_q;
   logic [REG_WIDTH-1:0]  rdata_q;
   logic [7:0]            drop_q;

   logic                  accept, capture, release_rsp, drop;
   logic [IDX_BITS-1:0]   req_idx, cap_idx;
   logic [REG_WIDTH-1:0]  cap_data;

   // Byte offset bits are discarded so misaligned addresses alias to their word.
   assign req_idx = S_2_MOD_RADDR[IDX_BITS+1:2];

   // With LATENCY=1 the capture happens on the accepting edge, so the index
   // comes straight from the bus rather than from the latched copy.
   assign cap_idx = (state == IDLE) ? req_idx : idx_q;

   // Address bits outside the index are only consumed by the out-of-range check.
   logic unused_addr;
   assign unused_addr = ^S_2_MOD_RADDR;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      capture     = 1'b0;
      release_rsp = 1'b0;
      drop        = 1'b0;
      case (state)
         IDLE: begin
            if (S_2_MOD_RREQ) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  capture   = 1'b1;
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            drop = S_2_MOD_RREQ;
            if (cnt == 8'd1) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            // A strobe on the handshake edge still sees RESP and is dropped.
            drop = S_2_MOD_RREQ;
            if (RREADY) begin
               release_rsp = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef AXIL_RESP_DECERR_EN
   logic oor_q, req_oor, cap_oor, rd_err_q;

   assign req_oor  = (S_2_MOD_RADDR >= REG_WIDTH'(4 * DEPTH));
   assign cap_oor  = (state == IDLE) ? req_oor : oor_q;
   assign cap_data = cap_oor ? REG_WIDTH'(32'hDEADBEEF) : reg_bank[cap_idx];

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         oor_q    <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         if (accept) begin
            oor_q <= req_oor;
         end
         if (capture) begin
            rd_err_q <= cap_oor;
         end else if (release_rsp) begin
            rd_err_q <= 1'b0;
         end
      end
   end

   assign RD_ERR = rd_err_q;
`else
   assign cap_data = reg_bank[cap_idx];
   assign RD_ERR   = 1'b0;
`endif

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         cnt     <= 8'd0;
         idx_q   <= '0;
         rrqst_q <= 1'b0;
         rdata_q <= '0;
         drop_q  <= 8'd0;
      end else begin
         if (accept) begin
            idx_q <= req_idx;
            cnt   <= 8'(LATENCY - 1);
         end else if (state == WAIT) begin
            cnt <= cnt - 8'd1;
         end

         // The bank is read with its pre-edge contents, so a write landing on
         // the capture edge is not visible in this response.
         if (capture) begin
            rrqst_q <= 1'b1;
            rdata_q <= cap_data;
         end else if (release_rsp) begin
            rrqst_q <= 1'b0;
            rdata_q <= '0;
         end

         if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            reg_bank[i] <= '0;
         end
      end else if (WR_EN) begin
         reg_bank[WR_IDX] <= WR_DATA;
      end
   end

   assign MOD_2_S_RRQST = rrqst_q;
   assign MOD_2_S_RDATA = rdata_q;
   assign BUSY          = (state != IDLE);
   assign DROP_CNT      = drop_q;

endmodule
